seg_mux_driver: RTL and testbench

- Downstream display stage for the switch-to-seven-segment datapath.
- Takes two 4-bit hex nibbles and time-multiplexes them onto one shared set of cathode lines (seg) plus two digit anode enables (an).
- Inserts dead-time blanking between digits to suppress ghosting.
- Outputs drive the board's PNP anode transistors and common seven-segment cathodes, all active-low.

---
 rtl/seg_mux_pkg.sv | 35 +++
 rtl/seven_seg_decoder.sv | 38 +++
 rtl/seg_mux_driver.sv | 134 +++++++++++++
 tb/tb_seg_mux_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mux_pkg
//  Purpose  : Shared types and constants for the two-digit multiplexed
//             seven-segment display stage.
//  Revision : 1.0  initial release
// ============================================================================
package seg_mux_pkg;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } mux_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_DIG0   = 2'b10;
    localparam logic [1:0] AN_DIG1   = 2'b01;

    // Fixed slot rotation; BLANK states sit between digits as dead time.
    function automatic mux_state_t next_slot(input mux_state_t s);
        mux_state_t n;
        case (s)
            BLANK0:  n = SHOW0;
            SHOW0:   n = BLANK1;
            BLANK1:  n = SHOW1;
            default: n = BLANK0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_decoder
//  Purpose  : Combinational hex nibble to active-low {g,f,e,d,c,b,a} lookup.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_decoder
    import seg_mux_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_mux_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mux_driver
//  Purpose  : Time-multiplexes two hex digits onto shared active-low cathodes
//             with dead-time blanking between digit slots.
//  Options  : SEG_MUX_LEADZERO_EN - blank digit 1 when its latched value is 0.
//  Revision : 1.0  initial release
// ============================================================================
module seg_mux_driver
    import seg_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int c_max_cnt = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int c_cnt_w   = (c_max_cnt > 1) ? $clog2(c_max_cnt) : 1;
    localparam logic [c_cnt_w-1:0] c_show_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_dead_last = c_cnt_w'(DEAD_CYCLES - 1);

    mux_state_t         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [3:0]         dig0_q, dig0_d;
    logic [3:0]         dig1_q, dig1_d;
    logic               wrap_q, wrap_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         an_q, an_d;
    logic               tick_q, tick_d;

    logic               w_slot_last;
    logic [3:0]         w_dec_nib;
    logic [6:0]         w_dec_seg;

    assign w_dec_nib = (state_q == SHOW1) ? dig1_q : dig0_q;

    seven_seg_decoder u_dec (
        .nib (w_dec_nib),
        .seg (w_dec_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        wrap_d  = 1'b0;
        seg_d   = SEG_BLANK;
        an_d    = AN_OFF;
        tick_d  = wrap_q;

        w_slot_last = (state_q == BLANK0 || state_q == BLANK1) ?
                      (cnt_q == c_dead_last) : (cnt_q == c_show_last);

        // Nibbles are captured only when their slot opens, so the digit is
        // stable for the whole lit period.
        if (w_slot_last) begin
            state_d = next_slot(state_q);
            cnt_d   = '0;
            if (state_q == BLANK0) dig0_d = s0;
            if (state_q == BLANK1) dig1_d = s1;
            if (state_q == SHOW1)  wrap_d = 1'b1;
        end

        case (state_q)
            SHOW0: begin
                an_d  = AN_DIG0;
                seg_d = w_dec_seg;
            end
            SHOW1: begin
`ifdef SEG_MUX_LEADZERO_EN
                if (dig1_q != 4'h0) begin
                    an_d  = AN_DIG1;
                    seg_d = w_dec_seg;
                end
`else
                an_d  = AN_DIG1;
                seg_d = w_dec_seg;
`endif
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        endcase

        // Disabled: park at the start of the frame with outputs dark; a later
        // restart is not a frame wrap, so no tick follows.
        if (!en) begin
            state_d = BLANK0;
            cnt_d   = '0;
            wrap_d  = 1'b0;
            seg_d   = SEG_BLANK;
            an_d    = AN_OFF;
            tick_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK0;
            cnt_q   <= '0;
            dig0_q  <= 4'h0;
            dig1_q  <= 4'h0;
            wrap_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_mux_driver
//  Purpose  : Self-checking bench for seg_mux_driver (REFRESH_DIV=4,
//             DEAD_CYCLES=2) against a frame-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_mux_driver;

    localparam int REFRESH_DIV = 4;
    localparam int DEAD_CYCLES = 2;
    localparam int FRAME       = 2 * (REFRESH_DIV + DEAD_CYCLES);

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: pos is the frame position (0..FRAME-1) of the FSM in the cycle
    // just started; outputs describe the position of the previous cycle.
    int         pos     = 0;
    bit         wrapped = 0;
    logic [3:0] l0 = 4'h0;
    logic [3:0] l1 = 4'h0;
    logic [6:0] exp_seg = 7'h7F;
    logic [1:0] exp_an  = 2'b11;
    logic       exp_tick = 1'b0;

    always #5 clk = ~clk;

    seg_mux_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .s0         (s0),
        .s1         (s1),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic model_edge();
        int show0_beg = DEAD_CYCLES;
        int blank1_beg = DEAD_CYCLES + REFRESH_DIV;
        int show1_beg = 2 * DEAD_CYCLES + REFRESH_DIV;
        if (reset) begin
            pos = 0; wrapped = 0; l0 = 4'h0; l1 = 4'h0;
            exp_seg = 7'h7F; exp_an = 2'b11; exp_tick = 1'b0;
        end else if (!en) begin
            pos = 0; wrapped = 0;
            exp_seg = 7'h7F; exp_an = 2'b11; exp_tick = 1'b0;
        end else begin
            exp_seg  = 7'h7F;
            exp_an   = 2'b11;
            exp_tick = (pos == 0) && wrapped;
            if (pos >= show0_beg && pos < blank1_beg) begin
                exp_an = 2'b10; exp_seg = dec_tab[l0];
            end else if (pos >= show1_beg) begin
`ifdef SEG_MUX_LEADZERO_EN
                if (l1 != 4'h0) begin
                    exp_an = 2'b01; exp_seg = dec_tab[l1];
                end
`else
                exp_an = 2'b01; exp_seg = dec_tab[l1];
`endif
            end
            if (pos == show0_beg - 1) l0 = s0;
            if (pos == show1_beg - 1) l1 = s1;
            if (pos == FRAME - 1) wrapped = 1;
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("FAIL seg observed=%b expected=%b", seg, exp_seg);
        end
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("FAIL an observed=%b expected=%b", an, exp_an);
        end
        checks++;
        assert (frame_tick === exp_tick) else begin
            errors++;
            $error("FAIL frame_tick observed=%b expected=%b", frame_tick, exp_tick);
        end
        checks++;
        assert (an !== 2'b00) else begin
            errors++;
            $error("FAIL an_both observed=%b expected=not 00", an);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; s0 = 4'h0; s1 = 4'h0;
        step(3);
        reset = 1'b0;

        s0 = 4'h8; s1 = 4'hA;
        step(2 * FRAME);

        // Mid-slot change on s0 must not reach seg until the next SHOW0.
        s0 = 4'h3;
        for (int i = 0; i < FRAME && pos != 0; i++) step(1);
        for (int i = 0; i < FRAME && pos != DEAD_CYCLES + 1; i++) step(1);
        s0 = 4'hF;
        step(FRAME + 2);

        // Drop en mid-SHOW1, then time the restart explicitly.
        for (int i = 0; i < FRAME && pos != 2 * DEAD_CYCLES + REFRESH_DIV + 1; i++) step(1);
        en = 1'b0;
        step(5);
        en = 1'b1;
        for (int k = 1; k <= DEAD_CYCLES + 1; k++) begin
            step(1);
            checks++;
            assert (an === ((k == DEAD_CYCLES + 1) ? 2'b10 : 2'b11)) else begin
                errors++;
                $error("FAIL restart_an k=%0d observed=%b expected=%b", k, an,
                       (k == DEAD_CYCLES + 1) ? 2'b10 : 2'b11);
            end
        end
        step(FRAME);

        s1 = 4'h0; s0 = 4'h5;
        step(2 * FRAME);
        s1 = 4'h1;
        step(2 * FRAME);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) s0 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) s1 = 4'($urandom);
            en    = ($urandom_range(0, 39) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step(1);
        end
        reset = 1'b0; en = 1'b1;
        step(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
